spi_slave_core: RTL and testbench

Parametrised SPI slave front end, successor to the fixed 16-bit mode-0 PMOD SPI logic. It oversamples SCK, SSEL and MOSI in the system clock domain and supports all four CPOL/CPHA modes, any word width, and MSB- or LSB-first order. Full-duplex operation: received words go out on a valid strobe, and transmit words are pulled through a valid/ready handshake. It sits between the PMOD pins and the user register/command logic.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_core.sv | 204 ++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared SPI mode constants, FSM encoding and counter sizing.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] c_MODE0 = 2'b00;
    localparam logic [1:0] c_MODE1 = 2'b01;
    localparam logic [1:0] c_MODE2 = 2'b10;
    localparam logic [1:0] c_MODE3 = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Two-flop synchroniser plus history flop with rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [2:0] r_sync;

    // Clearing to 0 means a select line held low through reset never
    // produces a spurious assertion edge afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], async_in};
        end
    end

    assign rise = r_sync[1] & ~r_sync[2];
    assign fall = ~r_sync[1] & r_sync[2];

endmodule
`default_nettype wire

// File: rtl/spi_slave_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spi_slave_core
// Purpose  : Oversampled full-duplex SPI slave, all CPOL/CPHA modes.
//            Optional SPI_SLAVE_ECHO_EN: underrun loads echo last rx word.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter bit                CPOL      = 1'b0,
    parameter bit                CPHA      = 1'b0,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_WORD = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ssel_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_err,
    output logic              tx_underrun
);

    localparam int               c_CNT_W       = cnt_width(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT  = c_CNT_W'(DATA_W - 1);
    localparam logic [1:0]       c_SPI_MODE    = {CPOL, CPHA};
    localparam bit               c_SAMPLE_RISE = (c_SPI_MODE == c_MODE0) || (c_SPI_MODE == c_MODE3);
    localparam bit               c_SHIFT_RISE  = (c_SPI_MODE == c_MODE1) || (c_SPI_MODE == c_MODE2);

    logic w_sck_rise, w_sck_fall, w_ssel_rise, w_ssel_fall;
    logic [1:0] r_mosi_sync;

    spi_sync_edge u_sync_sck (
        .clk      (clk),
        .rst      (rst),
        .async_in (sck),
        .rise     (w_sck_rise),
        .fall     (w_sck_fall)
    );

    spi_sync_edge u_sync_ssel (
        .clk      (clk),
        .rst      (rst),
        .async_in (ssel_n),
        .rise     (w_ssel_rise),
        .fall     (w_ssel_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mosi_sync <= 2'b00;
        end else begin
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    logic w_sample_edge, w_shift_edge;
    assign w_sample_edge = c_SAMPLE_RISE ? w_sck_rise : w_sck_fall;
    assign w_shift_edge  = c_SHIFT_RISE  ? w_sck_rise : w_sck_fall;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic                r_load_pending;
    logic [DATA_W-1:0]   r_rx_sh, r_tx_sh, r_rx_data;
    logic                r_rx_valid, r_frame_start, r_frame_end, r_frame_err;
    logic                r_tx_underrun, r_miso_oe;
    logic                w_enter, w_leave, w_sample, w_shift, w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A deselect in the same cycle as an SCK edge suppresses the edge.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_leave     = 1'b0;
        w_sample    = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ssel_fall) begin
                        w_state_nxt = ST_ACTIVE;
                        w_enter     = 1'b1;
                        w_load      = ~CPHA;
                    end
                end
                ST_ACTIVE: begin
                    if (w_ssel_rise) begin
                        w_state_nxt = ST_IDLE;
                        w_leave     = 1'b1;
                    end else begin
                        w_sample = w_sample_edge;
                        w_shift  = w_shift_edge & ~r_load_pending;
                        w_load   = w_shift_edge & r_load_pending;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    logic              w_word_done;
    logic [DATA_W-1:0] w_rx_next, w_tx_shifted, w_fill, w_load_word;

    assign w_word_done  = w_sample && (r_bit_cnt == c_LAST_BIT);
    assign w_rx_next    = MSB_FIRST ? {r_rx_sh[DATA_W-2:0], r_mosi_sync[1]}
                                    : {r_mosi_sync[1], r_rx_sh[DATA_W-1:1]};
    assign w_tx_shifted = MSB_FIRST ? {r_tx_sh[DATA_W-2:0], 1'b0}
                                    : {1'b0, r_tx_sh[DATA_W-1:1]};
`ifdef SPI_SLAVE_ECHO_EN
    assign w_fill = r_rx_data;
`else
    assign w_fill = IDLE_WORD;
`endif
    assign w_load_word  = tx_valid ? tx_data : w_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt      <= '0;
            r_load_pending <= 1'b0;
            r_rx_sh        <= '0;
            r_tx_sh        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_frame_start  <= 1'b0;
            r_frame_end    <= 1'b0;
            r_frame_err    <= 1'b0;
            r_tx_underrun  <= 1'b0;
            r_miso_oe      <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_start <= w_enter;
            r_frame_end   <= w_leave;
            r_frame_err   <= w_leave && (r_bit_cnt != '0);
            r_tx_underrun <= w_load && !tx_valid;

            if (w_enter) begin
                r_bit_cnt      <= '0;
                r_load_pending <= CPHA;
                r_rx_sh        <= '0;
                r_miso_oe      <= 1'b1;
            end

            // Partial RX bits and the in-flight TX word are dropped here.
            if (w_leave) begin
                r_bit_cnt      <= '0;
                r_load_pending <= 1'b0;
                r_rx_sh        <= '0;
                r_tx_sh        <= '0;
                r_miso_oe      <= 1'b0;
            end

            if (w_sample) begin
                r_rx_sh <= w_rx_next;
                if (w_word_done) begin
                    r_bit_cnt      <= '0;
                    r_rx_data      <= w_rx_next;
                    r_rx_valid     <= 1'b1;
                    r_load_pending <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_load) begin
                r_tx_sh        <= w_load_word;
                r_load_pending <= 1'b0;
            end else if (w_shift) begin
                r_tx_sh <= w_tx_shifted;
            end
        end
    end

    assign miso        = MSB_FIRST ? r_tx_sh[DATA_W-1] : r_tx_sh[0];
    assign miso_oe     = r_miso_oe;
    assign tx_ready    = w_load;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign frame_err   = r_frame_err;
    assign tx_underrun = r_tx_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_slave_core
// Purpose  : Scoreboard bench driving five mode/bit-order configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_core;

    localparam int DW   = 16;
    localparam int NCFG = 5;
    localparam int HALF = 5;
    // cfg0..3 = modes 0..3 MSB first, cfg4 = mode 3 LSB first
    localparam logic [NCFG-1:0] CFG_CPOL = 5'b11100;
    localparam logic [NCFG-1:0] CFG_CPHA = 5'b11010;
    localparam logic [NCFG-1:0] CFG_MSB  = 5'b01111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   sel = 0;

    logic          sck_v [NCFG];
    logic          ssel_n_v [NCFG];
    logic          mosi_v [NCFG];
    logic          miso_v [NCFG];
    logic          miso_oe_v [NCFG];
    logic          tx_ready_v [NCFG];
    logic [DW-1:0] rx_data_v [NCFG];
    logic          rx_valid_v [NCFG];
    logic          frame_start_v [NCFG];
    logic          frame_end_v [NCFG];
    logic          frame_err_v [NCFG];
    logic          tx_underrun_v [NCFG];

    logic [DW-1:0] tx_mem [256];
    logic          tx_vmem [256];
    logic [7:0]    gp = 8'd0;
    logic [DW-1:0] tx_data;
    logic          tx_valid;

    assign tx_data  = tx_mem[gp];
    assign tx_valid = tx_vmem[gp];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        spi_slave_core #(
            .DATA_W    (DW),
            .CPOL      (CFG_CPOL[g]),
            .CPHA      (CFG_CPHA[g]),
            .MSB_FIRST (CFG_MSB[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .sck         (sck_v[g]),
            .ssel_n      (ssel_n_v[g]),
            .mosi        (mosi_v[g]),
            .miso        (miso_v[g]),
            .miso_oe     (miso_oe_v[g]),
            .tx_data     (tx_data),
            .tx_valid    (tx_valid),
            .tx_ready    (tx_ready_v[g]),
            .rx_data     (rx_data_v[g]),
            .rx_valid    (rx_valid_v[g]),
            .frame_start (frame_start_v[g]),
            .frame_end   (frame_end_v[g]),
            .frame_err   (frame_err_v[g]),
            .tx_underrun (tx_underrun_v[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;
    int n_fs = 0;
    int n_ur = 0;

    logic [DW-1:0] rx_q [$];
    bit            fe_q [$];
    logic [DW-1:0] host_w [4];
    logic [DW-1:0] last_rx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cfg %0d): got %0h expected %0h at %0t", name, sel, act, exp, $time);
        end
    endtask

    // Transmit stream pointer advances on every accepted load strobe.
    always @(posedge clk) begin
        if (!rst && tx_ready_v[sel]) gp <= gp + 8'd1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid_v[sel]) begin
                check("rx_valid has expectation", rx_q.size() != 0, 1);
                if (rx_q.size() != 0) check("rx_data", rx_data_v[sel], rx_q.pop_front());
            end
            if (frame_end_v[sel]) begin
                check("frame_end has expectation", fe_q.size() != 0, 1);
                if (fe_q.size() != 0) check("frame_err", frame_err_v[sel], fe_q.pop_front());
            end else begin
                check("frame_err only with frame_end", frame_err_v[sel], 0);
            end
            if (frame_start_v[sel]) n_fs++;
            if (tx_underrun_v[sel]) n_ur++;
        end
    end

    task automatic half();
        repeat (HALF) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("outputs zero in reset",
              {miso_v[sel], miso_oe_v[sel], tx_ready_v[sel], rx_valid_v[sel], frame_start_v[sel],
               frame_end_v[sel], frame_err_v[sel], tx_underrun_v[sel], rx_data_v[sel]}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        last_rx = '0;
        repeat (4) @(posedge clk);
        #2;
    endtask

    function automatic logic host_bit(input int b, input bit msb);
        int i;
        i = b % DW;
        return host_w[b / DW][msb ? (DW - 1 - i) : i];
    endfunction

    task automatic set_tx(input int k, input logic [DW-1:0] d, input logic v);
        tx_mem[8'(gp + k)]  = d;
        tx_vmem[8'(gp + k)] = v;
    endtask

    // nw full words, then pbits of a partial word; abort = reset mid-word
    task automatic host_frame(input int nw, input int pbits, input bit abort);
        bit            cpol, cpha, msb;
        int            nbits, nstart, fs0, ur0, exp_ur, j, i, pos;
        logic [7:0]    gp0, nl;
        logic [DW-1:0] exp_tx [4];
        logic [DW-1:0] got;
        cpol   = CFG_CPOL[sel];
        cpha   = CFG_CPHA[sel];
        msb    = CFG_MSB[sel];
        nbits  = nw * DW + pbits;
        nstart = nw + ((pbits > 0) ? 1 : 0);
        gp0    = gp;
        fs0    = n_fs;
        ur0    = n_ur;
        exp_ur = 0;
        got    = '0;
        for (int k = 0; k < nstart; k++) begin
            if (tx_vmem[8'(gp0 + k)]) begin
                exp_tx[k] = tx_mem[8'(gp0 + k)];
            end else begin
                exp_ur++;
`ifdef SPI_SLAVE_ECHO_EN
                exp_tx[k] = (k == 0) ? last_rx : host_w[(k == 0) ? 0 : k - 1];
`else
                exp_tx[k] = '0;
`endif
            end
        end
        for (int k = 0; k < nw; k++) rx_q.push_back(host_w[k]);
        if (!abort) fe_q.push_back(pbits > 0);

        ssel_n_v[sel] = 1'b0;
        if (!cpha) mosi_v[sel] = host_bit(0, msb);
        half();
        for (int b = 0; b < nbits; b++) begin
            j   = b / DW;
            i   = b % DW;
            pos = msb ? (DW - 1 - i) : i;
            if (!cpha) begin
                got[pos]   = miso_v[sel];
                sck_v[sel] = !cpol;
                half();
                sck_v[sel] = cpol;
                if (b == nbits - 1) begin
                    if (!abort) ssel_n_v[sel] = 1'b1;
                end else begin
                    mosi_v[sel] = host_bit(b + 1, msb);
                end
                half();
            end else begin
                sck_v[sel]  = !cpol;
                mosi_v[sel] = host_bit(b, msb);
                half();
                got[pos]   = miso_v[sel];
                sck_v[sel] = cpol;
                half();
            end
            if (i == DW - 1) begin
                check("miso word", got, exp_tx[j]);
                got = '0;
            end
        end

        if (abort) begin
            do_reset();
            ssel_n_v[sel] = 1'b1;
            half();
        end else if (cpha) begin
            ssel_n_v[sel] = 1'b1;
        end
        half(); half(); half();
        nl = gp - gp0;
        check("tx load count", nl, nstart);
        check("frame_start count", n_fs - fs0, 1);
        check("tx_underrun count", n_ur - ur0, exp_ur);
        if (abort) last_rx = '0;
        else if (nw > 0) last_rx = host_w[nw - 1];
    endtask

    task automatic random_frame();
        int nw, pb;
        nw = $urandom_range(1, 3);
        pb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW - 1) : 0;
        for (int k = 0; k < 4; k++) begin
            host_w[k] = DW'($urandom);
            set_tx(k, DW'($urandom), $urandom_range(0, 3) != 0);
        end
        host_frame(nw, pb, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NCFG; k++) begin
            sck_v[k]    = CFG_CPOL[k];
            ssel_n_v[k] = 1'b1;
            mosi_v[k]   = 1'b0;
        end
        for (int k = 0; k < 256; k++) begin
            tx_mem[k]  = '0;
            tx_vmem[k] = 1'b0;
        end

        for (int c = 0; c < NCFG; c++) begin
            sel = c;
            do_reset();

            host_w[0] = 16'hA5C3;
            set_tx(0, 16'h1234, 1'b1);
            host_frame(1, 0, 1'b0);

            host_w[0] = 16'h1111; host_w[1] = 16'h2222; host_w[2] = 16'h3333;
            set_tx(0, 16'h0001, 1'b1);
            set_tx(1, 16'h0002, 1'b1);
            set_tx(2, 16'h0003, 1'b1);
            host_frame(3, 0, 1'b0);

            host_w[0] = 16'hBEEF;
            set_tx(0, 16'h5A5A, 1'b1);
            host_frame(1, 0, 1'b0);
            host_w[0] = 16'h0F0F;
            set_tx(0, 16'h7777, 1'b0);
            host_frame(1, 0, 1'b0);

            host_w[0] = 16'hFFFF;
            set_tx(0, 16'hC001, 1'b1);
            host_frame(0, 9, 1'b0);
            host_w[0] = 16'h3C3C;
            set_tx(0, 16'h4242, 1'b1);
            host_frame(1, 0, 1'b0);

            host_w[0] = 16'h6E21; host_w[1] = 16'h9999;
            set_tx(0, 16'h8181, 1'b1);
            set_tx(1, 16'h2468, 1'b1);
            host_frame(1, 5, 1'b1);
            host_w[0] = 16'hC3A5;
            set_tx(0, 16'hE00F, 1'b1);
            host_frame(1, 0, 1'b0);

            repeat (3) random_frame();
        end

        check("rx expectations drained", rx_q.size(), 0);
        check("frame_end expectations drained", fe_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
